// File: rtl/pic_ack_sequencer.sv
// Interrupt-acknowledge sequencer and in-service register for an 8-level 8259-style PIC.
// Converts a resolved priority level back into ISR set/clear actions, IRR clear pulses and the vector byte.
module pic_ack_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irr,
    input  logic [4:0] icw2_base,
    input  logic       aeoi,
    input  logic       inta_n,
    input  logic       eoi_ns,
    input  logic       eoi_sp,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] isr,
    output logic [7:0] clr_irr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    // Handshake: inta_n is a level strobe synchronous to clk; each low pulse is one
    // acknowledge cycle, and only its sampled falling/rising edges advance the FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        GAP  = 2'd2,
        ACK2 = 2'd3
    } state_t;

    state_t     state;
    logic       inta_prev;
    logic [2:0] level;
    logic       spurious;

    logic       fall;
    logic       rise;
    logic [2:0] winner;
    logic [3:0] cur_lvl;
    logic       req;
    logic [7:0] isr_low;
    logic [7:0] eoi_mask;
    logic [7:0] aeoi_mask;
    logic [7:0] set_mask;
    logic [7:0] isr_next;

    assign fall = inta_prev & ~inta_n;
    assign rise = ~inta_prev & inta_n;

    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (irr[i]) winner = i[2:0];
        end
        cur_lvl = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (isr[i]) cur_lvl = i[3:0];
        end
    end

    assign req = (irr != 8'd0) && ({1'b0, winner} < cur_lvl);

    // Two's-complement trick isolates the lowest set (highest priority) ISR bit.
    assign isr_low = isr & (~isr + 8'd1);

    always_comb begin
        eoi_mask = 8'd0;
        if (eoi_sp)
            eoi_mask = 8'd1 << eoi_level;
        else if (eoi_ns)
            eoi_mask = isr_low;

        aeoi_mask = 8'd0;
        if (state == ACK2 && rise && aeoi && !spurious)
            aeoi_mask = 8'd1 << level;

        set_mask = 8'd0;
        if (state == IDLE && fall && int_out)
            set_mask = 8'd1 << winner;

        // Set is applied after clear so a same-bit collision leaves the bit set.
        isr_next = (isr & ~(eoi_mask | aeoi_mask)) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            inta_prev <= 1'b1;
            level     <= 3'd0;
            spurious  <= 1'b0;
            isr       <= 8'd0;
            int_out   <= 1'b0;
            clr_irr   <= 8'd0;
            data_out  <= 8'd0;
            data_oe   <= 1'b0;
        end else begin
            inta_prev <= inta_n;
            isr       <= isr_next;
            clr_irr   <= 8'd0;
            int_out   <= 1'b0;
            case (state)
                IDLE: begin
                    int_out <= req;
                    if (fall) begin
                        int_out <= 1'b0;
                        state   <= ACK1;
                        if (int_out) begin
                            level    <= winner;
                            spurious <= 1'b0;
                            clr_irr  <= 8'd1 << winner;
                        end else begin
                            level    <= 3'd7;
                            spurious <= 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (rise) state <= GAP;
                end
                GAP: begin
                    if (fall) begin
                        state    <= ACK2;
                        data_oe  <= 1'b1;
                        data_out <= {icw2_base, level};
                    end
                end
                ACK2: begin
                    if (rise) begin
                        state    <= IDLE;
                        data_oe  <= 1'b0;
                        data_out <= 8'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Directed self-checking bench for pic_ack_sequencer: ack, nesting, EOI, AEOI, spurious, collision, reset.
module tb_pic_ack_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] irr;
    logic [4:0] icw2_base;
    logic       aeoi;
    logic       inta_n;
    logic       eoi_ns;
    logic       eoi_sp;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] clr_irr;
    logic [7:0] data_out;
    logic       data_oe;

    int checks = 0;
    int errors = 0;

    pic_ack_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irr       (irr),
        .icw2_base (icw2_base),
        .aeoi      (aeoi),
        .inta_n    (inta_n),
        .eoi_ns    (eoi_ns),
        .eoi_sp    (eoi_sp),
        .eoi_level (eoi_level),
        .int_out   (int_out),
        .isr       (isr),
        .clr_irr   (clr_irr),
        .data_out  (data_out),
        .data_oe   (data_oe)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic wait_int(input string name);
        int n;
        n = 0;
        while (int_out !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL %s: int_out never rose, got %b want 1", name, int_out);
        end
    endtask

    // Full two-pulse acknowledge; the requesting IRR bit is dropped after the first pulse.
    task automatic ack_seq(input logic [7:0] irr_after);
        inta_n = 1'b0; tick();
        irr = irr_after;
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        tick();
        inta_n = 1'b1; tick();
    endtask

    task automatic pulse_eoi(input logic ns, input logic sp, input logic [2:0] lvl);
        eoi_ns = ns; eoi_sp = sp; eoi_level = lvl;
        tick();
        eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_level = 3'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irr = 8'd0; icw2_base = 5'b01000; aeoi = 1'b0;
        inta_n = 1'b1; eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_level = 3'd0;
        tick(); tick();
        checks++;
        if ({int_out, isr, clr_irr, data_out, data_oe} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {int_out, isr, clr_irr, data_out, data_oe});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_ack();
        irr = 8'h24;
        tick();
        checks++;
        if (int_out !== 1'b1) begin errors++; $display("FAIL basic_int: got %b want 1", int_out); end
        inta_n = 1'b0; tick();
        checks++;
        if (clr_irr !== 8'h04) begin errors++; $display("FAIL basic_clr: got %h want 04", clr_irr); end
        checks++;
        if (isr !== 8'h04) begin errors++; $display("FAIL basic_isr: got %h want 04", isr); end
        checks++;
        if (int_out !== 1'b0) begin errors++; $display("FAIL basic_int_drop: got %b want 0", int_out); end
        irr = 8'h20;
        inta_n = 1'b1; tick();
        checks++;
        if (clr_irr !== 8'h00) begin errors++; $display("FAIL basic_clr_one_cycle: got %h want 00", clr_irr); end
        checks++;
        if (data_oe !== 1'b0) begin errors++; $display("FAIL basic_oe_early: got %b want 0", data_oe); end
        inta_n = 1'b0; tick();
        checks++;
        if (data_oe !== 1'b1 || data_out !== 8'h42) begin
            errors++; $display("FAIL basic_vector: got oe=%b data=%h want oe=1 data=42", data_oe, data_out);
        end
        tick();
        checks++;
        if (data_oe !== 1'b1 || data_out !== 8'h42) begin
            errors++; $display("FAIL basic_vector_hold: got oe=%b data=%h want oe=1 data=42", data_oe, data_out);
        end
        inta_n = 1'b1; tick();
        checks++;
        if (data_oe !== 1'b0 || data_out !== 8'h00 || isr !== 8'h04) begin
            errors++; $display("FAIL basic_end: got oe=%b data=%h isr=%h want 0 00 04", data_oe, data_out, isr);
        end
        tick(); tick();
        checks++;
        if (int_out !== 1'b0) begin errors++; $display("FAIL basic_blocked: got %b want 0", int_out); end
        irr = 8'h00;
        pulse_eoi(1'b0, 1'b1, 3'd2);
        tick();
        checks++;
        if (isr !== 8'h00) begin errors++; $display("FAIL basic_cleanup: got %h want 00", isr); end
    endtask

    task automatic test_nesting();
        irr = 8'h10;
        wait_int("nest_first");
        ack_seq(8'h00);
        checks++;
        if (isr !== 8'h10) begin errors++; $display("FAIL nest_isr10: got %h want 10", isr); end
        irr = 8'h02;
        wait_int("nest_second");
        ack_seq(8'h00);
        checks++;
        if (isr !== 8'h12) begin errors++; $display("FAIL nest_isr12: got %h want 12", isr); end
    endtask

    task automatic test_eoi();
        pulse_eoi(1'b1, 1'b0, 3'd0);
        checks++;
        if (isr !== 8'h10) begin errors++; $display("FAIL eoi_ns: got %h want 10", isr); end
        pulse_eoi(1'b0, 1'b1, 3'd4);
        checks++;
        if (isr !== 8'h00) begin errors++; $display("FAIL eoi_sp: got %h want 00", isr); end
        pulse_eoi(1'b1, 1'b0, 3'd0);
        checks++;
        if (isr !== 8'h00) begin errors++; $display("FAIL eoi_ns_empty: got %h want 00", isr); end
    endtask

    task automatic test_nesting_blocked();
        irr = 8'h02;
        wait_int("block_setup");
        ack_seq(8'h00);
        irr = 8'h10;
        tick(); tick(); tick();
        checks++;
        if (int_out !== 1'b0 || isr !== 8'h02) begin
            errors++; $display("FAIL nest_blocked: got int=%b isr=%h want 0 02", int_out, isr);
        end
        // Both EOIs together: specific (level 4, already clear) wins, so isr[1] must survive.
        pulse_eoi(1'b1, 1'b1, 3'd4);
        checks++;
        if (isr !== 8'h02) begin errors++; $display("FAIL eoi_sp_priority: got %h want 02", isr); end
        tick();
        checks++;
        if (int_out !== 1'b0) begin errors++; $display("FAIL nest_still_blocked: got %b want 0", int_out); end
        irr = 8'h00;
        pulse_eoi(1'b0, 1'b1, 3'd1);
    endtask

    task automatic test_aeoi();
        aeoi = 1'b1; irr = 8'h80;
        wait_int("aeoi_int");
        inta_n = 1'b0; tick();
        irr = 8'h00;
        checks++;
        if (isr !== 8'h80 || clr_irr !== 8'h80) begin
            errors++; $display("FAIL aeoi_set: got isr=%h clr=%h want 80 80", isr, clr_irr);
        end
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        checks++;
        if (data_out !== 8'h47 || data_oe !== 1'b1 || isr !== 8'h80) begin
            errors++; $display("FAIL aeoi_vector: got data=%h oe=%b isr=%h want 47 1 80", data_out, data_oe, isr);
        end
        inta_n = 1'b1; tick();
        checks++;
        if (isr !== 8'h00 || data_oe !== 1'b0) begin
            errors++; $display("FAIL aeoi_clear: got isr=%h oe=%b want 00 0", isr, data_oe);
        end
        aeoi = 1'b0;
    endtask

    task automatic test_spurious();
        irr = 8'h02;
        wait_int("spur_setup");
        ack_seq(8'h00);
        tick();
        aeoi = 1'b1;
        checks++;
        if (int_out !== 1'b0) begin errors++; $display("FAIL spur_noint: got %b want 0", int_out); end
        inta_n = 1'b0; tick();
        checks++;
        if (clr_irr !== 8'h00 || isr !== 8'h02) begin
            errors++; $display("FAIL spur_first: got clr=%h isr=%h want 00 02", clr_irr, isr);
        end
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        checks++;
        if (data_out !== 8'h47 || data_oe !== 1'b1) begin
            errors++; $display("FAIL spur_vector: got data=%h oe=%b want 47 1", data_out, data_oe);
        end
        inta_n = 1'b1; tick();
        checks++;
        if (isr !== 8'h02) begin errors++; $display("FAIL spur_isr_kept: got %h want 02", isr); end
        aeoi = 1'b0;
        pulse_eoi(1'b0, 1'b1, 3'd1);
    endtask

    task automatic test_collision_reset();
        irr = 8'h08;
        wait_int("coll_int");
        inta_n = 1'b0; eoi_sp = 1'b1; eoi_level = 3'd3;
        tick();
        eoi_sp = 1'b0; eoi_level = 3'd0; irr = 8'h00;
        checks++;
        if (isr !== 8'h08) begin errors++; $display("FAIL collision_set_wins: got %h want 08", isr); end
        inta_n = 1'b1; tick();
        rst_n = 1'b0; tick();
        checks++;
        if ({int_out, isr, clr_irr, data_out, data_oe} !== 26'd0) begin
            errors++; $display("FAIL reset_gap_outputs: got %h want 0", {int_out, isr, clr_irr, data_out, data_oe});
        end
        checks++;
        if (dut.state !== 2'd0) begin errors++; $display("FAIL reset_gap_state: got %0d want 0", dut.state); end
        rst_n = 1'b1; tick();
        // A lone falling edge after reset must be treated as a first pulse, not a GAP->ACK2 step.
        inta_n = 1'b0; tick();
        checks++;
        if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_no_vector: got %b want 0", data_oe); end
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_basic_ack();
        test_nesting();
        test_eoi();
        test_nesting_blocked();
        test_aeoi();
        test_spurious();
        test_collision_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pic_ack_sequencer.md
# pic_ack_sequencer

Interrupt-acknowledge sequencer and in-service register (ISR) for the 8259-compatible controller. It is the inverse of the priority encoder. The encoder turns a request bit vector into a level number. This block takes a resolved level number and turns it back into one-hot ISR set/clear actions and IRR clear pulses. It sits between the masked IRR, the CPU INTA strobe, the OCW2 EOI decode and the data-bus driver, and it runs the two-pulse 8086-mode INTA sequence.

## Interface
- No parameters. Width is fixed at 8 levels, with level 0 the highest priority.
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- irr  in  8  masked interrupt request register.
- icw2_base  in  5  vector base T7..T3 from ICW2.
- aeoi  in  1  automatic-EOI mode from ICW4.
- inta_n  in  1  CPU acknowledge strobe, active-low, synchronous to clk.
- eoi_ns  in  1  non-specific EOI command, one-cycle pulse.
- eoi_sp  in  1  specific EOI command, one-cycle pulse.
- eoi_level  in  3  level addressed by eoi_sp.
- int_out  out  1  interrupt request to the CPU, registered.
- isr  out  8  in-service register.
- clr_irr  out  8  one-hot, one-cycle pulse that clears the acknowledged IRR bit.
- data_out  out  8  vector byte {icw2_base, level}.
- data_oe  out  1  data bus drive enable.

## Operation
- **Winner:** the lowest set index of irr. Its level is 3 bits, produced by the same priority rule as the encoder.
- **Current ISR level:** the lowest set index of isr, or 8 if isr is empty.
- **Request condition (fully nested):** irr is non-zero and winner < current ISR level.
- **States:** IDLE, ACK1, GAP, ACK2.
- **Edge detection:** the previous value of inta_n is registered. A falling edge is prev=1 & inta_n=0; a rising edge is prev=0 & inta_n=1.
- **IDLE:**
  - int_out <= request condition.
  - On a falling edge with int_out=1: latch level=winner, set isr[level], pulse clr_irr[level], int_out <= 0, go to ACK1.
  - On a falling edge with int_out=0 (spurious): latch level=7, leave isr and irr untouched, go to ACK1.
- **ACK1:** on a rising edge, go to GAP.
- **GAP:** on a falling edge, go to ACK2 and set data_oe=1, data_out={icw2_base, level}.
- **ACK2:**
  - Hold data_oe and data_out while inta_n stays low.
  - On a rising edge: data_oe <= 0, data_out <= 0.
  - If aeoi=1 and the sequence was not spurious, clear isr[level].
  - Go to IDLE.
- int_out stays 0 in every state except IDLE.
- **EOI commands:** accepted in any state.
  - eoi_ns clears the lowest set isr bit. It has no effect if isr=0.
  - eoi_sp clears isr[eoi_level], even if that bit is already 0.
  - If eoi_ns and eoi_sp arrive together, eoi_sp wins and eoi_ns is ignored.
- **Simultaneous ISR set and EOI clear in one cycle:** both apply. If they target the same bit, set wins.
- **Level decode:** a 3-bit level maps to one-hot as 1<<level. No width extension is needed.

## Timing
- **Reset values:** state=IDLE, isr=0, int_out=0, clr_irr=0, data_out=0, data_oe=0, level=0, inta_n prev=1.
- Reset asserted mid-sequence aborts to IDLE with all outputs at their reset values on the next edge.
- **int_out latency:** asserted 1 cycle after the request condition becomes true in IDLE. Deasserted on the same edge that detects the first INTA falling edge.
- **clr_irr and isr set:** both occur on the first-INTA falling-edge cycle. clr_irr is high for exactly that 1 cycle.
- **data_oe:** high from the edge after the second falling edge is sampled, through the cycle the rising edge is sampled.
- **EOI latency:** isr changes 1 cycle after the EOI pulse.
- **AEOI latency:** isr clears on the second-INTA rising-edge cycle.
- A new request can raise int_out no earlier than 1 cycle after returning to IDLE.

## Test plan
- **Basic ack:** irr=8'h24, icw2_base=5'b01000, aeoi=0, two INTA pulses. Expect: int_out=1; clr_irr=8'h04 for one cycle; isr=8'h04; data_out=8'h42 with data_oe=1 during the second pulse; int_out stays 0 while irr=8'h20 because level 5 is blocked by ISR level 2.
- **Nesting:** isr=8'h10, irr=8'h02. Expect int_out=1 and isr=8'h12 after the ack. With isr=8'h02 and irr=8'h10, expect int_out=0.
- **EOI:** isr=8'h12, eoi_ns pulse gives isr=8'h10. Then eoi_sp with eoi_level=4 gives isr=8'h00. eoi_ns with isr=0 leaves isr unchanged.
- **AEOI:** aeoi=1, irr=8'h80, full sequence. Expect data_out={base,3'd7}; isr=8'h80 during the sequence and 8'h00 after the second rising edge.
- **Spurious:** int_out=0 and two INTA pulses. Expect isr unchanged, clr_irr=0, data_out={base,3'd7}.
- **Collision and reset:** eoi_sp with eoi_level=3 in the same cycle as an ack of level 3; expect isr[3]=1. Assert rst_n=0 during GAP; expect all outputs 0 and state IDLE next cycle.
